// File: rtl/music_strip_pkg.sv
// +----------------------------------------------------------------------+
// | music_strip_pkg: shared types and default strip timing constants.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package music_strip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } ws_state_e;

  // Defaults assume a 100 MHz clock.
  localparam int WS_BIT_CYCLES   = 125;
  localparam int WS_T0H_CYCLES   = 40;
  localparam int WS_T1H_CYCLES   = 80;
  localparam int WS_RESET_CYCLES = 5000;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } ws_pixel_t;

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_gen.sv
// +----------------------------------------------------------------------+
// | ws2812_bit_gen: one NRZ bit period; start restarts phase at zero.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ws2812_bit_gen #(
  parameter int BIT_CYCLES = 125,
  parameter int T0H_CYCLES = 40,
  parameter int T1H_CYCLES = 80
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic bit_i,
  output logic dout_next_o,
  output logic bit_end_o
);

  localparam int PW = $clog2(BIT_CYCLES);
  localparam logic [PW-1:0] c_last = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] c_t0h  = PW'(T0H_CYCLES);
  localparam logic [PW-1:0] c_t1h  = PW'(T1H_CYCLES);

  logic [PW-1:0] phase_q, phase_d;
  logic          bit_q, bit_d;
  logic          active_q, active_d;

  // A start on the bit_end cycle chains bits with no idle phase in between.
  always_comb begin
    phase_d  = phase_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (start_i) begin
      phase_d  = '0;
      bit_d    = bit_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (phase_q == c_last) begin
        active_d = 1'b0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

  assign dout_next_o = active_q && (phase_q < (bit_q ? c_t1h : c_t0h));
  assign bit_end_o   = active_q && (phase_q == c_last);

endmodule

`default_nettype wire

// File: rtl/ws2812_tx.sv
// +----------------------------------------------------------------------+
// | ws2812_tx: GRB pixel stream to WS2812 NRZ line with latch period.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ws2812_tx
  import music_strip_pkg::*;
#(
  parameter int BIT_CYCLES   = WS_BIT_CYCLES,
  parameter int T0H_CYCLES   = WS_T0H_CYCLES,
  parameter int T1H_CYCLES   = WS_T1H_CYCLES,
  parameter int RESET_CYCLES = WS_RESET_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(RESET_CYCLES - 1);

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
    $error("ws2812_tx: require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  ws_state_e     state_q, state_d;
  ws_pixel_t     hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_full_q, hold_full_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    idx_q, idx_d;
  logic          cur_last_q, cur_last_d;
  logic          last_pending_q, last_pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          underrun_q, underrun_d;
  logic          pix_ready_q, dout_q, busy_q;

  logic w_accept, w_load, w_start, w_bit, w_dout_next, w_bit_end;

  assign w_accept = pix_valid && pix_ready_q;

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    hold_last_d    = hold_last_q;
    shift_d        = shift_q;
    idx_d          = idx_q;
    cur_last_d     = cur_last_q;
    last_pending_d = last_pending_q;
    cnt_d          = cnt_q;
    frame_done_d   = 1'b0;
    underrun_d     = 1'b0;
    w_load         = 1'b0;
    w_start        = 1'b0;
    w_bit          = 1'b0;

    case (state_q)
      IDLE: w_load = hold_full_q;
      SEND: begin
        if (w_bit_end) begin
          if (idx_q != 5'd0) begin
            w_start = 1'b1;
            w_bit   = shift_q[22];
            shift_d = {shift_q[22:0], 1'b0};
            idx_d   = idx_q - 5'd1;
          end else if (cur_last_q) begin
            state_d = LATCH;
            cnt_d   = '0;
          end else if (hold_full_q) begin
            w_load = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (hold_full_q) begin
          w_load = 1'b1;
        end else if (cnt_q == c_cnt_last) begin
          underrun_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH: begin
        if (cnt_q == c_cnt_last) begin
          frame_done_d   = 1'b1;
          last_pending_d = 1'b0;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_load) begin
      w_start    = 1'b1;
      w_bit      = hold_q.g[7];
      shift_d    = hold_q;
      idx_d      = 5'd23;
      cur_last_d = hold_last_q;
      cnt_d      = '0;
      state_d    = SEND;
    end

    // The serializer takes the old hold content before a same-edge accept overwrites it.
    hold_full_d = (hold_full_q && !w_load) || w_accept;
    if (w_accept) begin
      hold_d      = pix_data;
      hold_last_d = pix_last;
      if (pix_last) begin
        last_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      hold_last_q    <= 1'b0;
      hold_full_q    <= 1'b0;
      shift_q        <= '0;
      idx_q          <= '0;
      cur_last_q     <= 1'b0;
      last_pending_q <= 1'b0;
      cnt_q          <= '0;
      frame_done_q   <= 1'b0;
      underrun_q     <= 1'b0;
      pix_ready_q    <= 1'b0;
      dout_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      hold_last_q    <= hold_last_d;
      hold_full_q    <= hold_full_d;
      shift_q        <= shift_d;
      idx_q          <= idx_d;
      cur_last_q     <= cur_last_d;
      last_pending_q <= last_pending_d;
      cnt_q          <= cnt_d;
      frame_done_q   <= frame_done_d;
      underrun_q     <= underrun_d;
      // Registered last_pending delays ready by one edge after frame_done.
      pix_ready_q    <= !hold_full_d && !last_pending_q;
      dout_q         <= w_dout_next;
      busy_q         <= (state_d != IDLE);
    end
  end

  ws2812_bit_gen #(
    .BIT_CYCLES(BIT_CYCLES),
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES)
  ) u_bit_gen (
    .clk        (clk),
    .rst        (rst),
    .start_i    (w_start),
    .bit_i      (w_bit),
    .dout_next_o(w_dout_next),
    .bit_end_o  (w_bit_end)
  );

  assign pix_ready  = pix_ready_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_tx.sv
// +----------------------------------------------------------------------+
// | tb_ws2812_tx: directed self-checking bench for ws2812_tx.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ws2812_tx;

  localparam int BIT   = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int RST_C = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_valid;
  logic        pix_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int n_underrun = 0;
  int n_frame_done = 0;
  int lat, lat_s, hi, fd0, ur0;
  logic [23:0] stream [3];

  always #5 clk = ~clk;

  ws2812_tx #(
    .BIT_CYCLES  (BIT),
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .RESET_CYCLES(RST_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .dout      (dout),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  always @(negedge clk) begin
    if (underrun === 1'b1) n_underrun++;
    if (frame_done === 1'b1) n_frame_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rise(output int n, input int lim);
    n = 0;
    while (dout !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  // Samples 24 bit periods, one negedge per cycle, starting on the first high sample.
  task automatic check_bits(input logic [23:0] px, input string tag);
    logic [9:0] seen, want;
    for (int b = 23; b >= 0; b--) begin
      for (int k = 0; k < BIT; k++) begin
        seen[k] = dout;
        want[k] = (k < (px[b] ? T1H : T0H));
        tick();
      end
      check($sformatf("%s_bit%0d", tag, b), {22'd0, seen}, {22'd0, want});
    end
  endtask

  // Called on the sample just after a pixel's final bit period.
  task automatic wait_pulse(input bit is_underrun, input logic exp_ready, input string tag);
    int c = 0;
    int h = 0;
    while (((is_underrun ? underrun : frame_done) !== 1'b1) && c < 200) begin
      if (dout) h++;
      tick();
      c++;
    end
    check({tag, "_delay"}, c, RST_C - 1);
    check({tag, "_dout_low"}, h, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_ready_at_pulse"}, {31'd0, pix_ready}, {31'd0, exp_ready});
    tick();
    check({tag, "_one_cycle"}, {31'd0, is_underrun ? underrun : frame_done}, 0);
  endtask

  task automatic send(input logic [23:0] px, input logic last, input string tag);
    int w = 0;
    pix_data  = px;
    pix_last  = last;
    pix_valid = 1'b1;
    while (!pix_ready && w < 400) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, {31'd0, pix_ready}, 1);
    tick();
    pix_valid = 1'b0;
    check({tag, "_ready_drop"}, {31'd0, pix_ready}, 0);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    stream[0] = 24'hFFFFFF; stream[1] = 24'h000000; stream[2] = 24'h123456;
    repeat (3) tick();
    check("rst_dout", {31'd0, dout}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, pix_ready}, 0);
    check("rst_fd", {31'd0, frame_done}, 0);
    check("rst_ur", {31'd0, underrun}, 0);
    rst = 1'b0;
    #1 check("ready_before_edge", {31'd0, pix_ready}, 0);
    tick();
    check("ready_after_release", {31'd0, pix_ready}, 1);

    // Single-pixel frame
    send(24'hA50F81, 1'b1, "single");
    wait_rise(lat, 10);
    check("single_latency", lat, 2);
    check("single_busy", {31'd0, busy}, 1);
    check_bits(24'hA50F81, "single");
    wait_pulse(1'b0, 1'b0, "single_latch");
    check("single_ready_after", {31'd0, pix_ready}, 1);

    // Three back-to-back pixels with valid held high
    fork
      begin : feed
        int w;
        for (int i = 0; i < 3; i++) begin
          pix_data  = stream[i];
          pix_last  = (i == 2);
          pix_valid = 1'b1;
          w = 0;
          while (!pix_ready && w < 400) begin
            tick();
            w++;
          end
          check("stream_ready", {31'd0, pix_ready}, 1);
          tick();
          check("stream_hold_full", {31'd0, pix_ready}, 0);
        end
        pix_valid = 1'b0;
      end
      begin : mon
        wait_rise(lat_s, 20);
        check("stream_rise", {31'd0, dout}, 1);
        check_bits(24'hFFFFFF, "stream0");
        check_bits(24'h000000, "stream1");
        check_bits(24'h123456, "stream2");
        wait_pulse(1'b0, 1'b0, "stream_latch");
      end
    join

    // Gap shorter than the timeout
    ur0 = n_underrun;
    send(24'hC3C3C3, 1'b0, "gap1");
    wait_rise(lat, 10);
    check("gap1_latency", lat, 2);
    check_bits(24'hC3C3C3, "gap1");
    hi = 0;
    repeat (29) begin
      if (dout) hi++;
      tick();
    end
    check("gap_dout_low", hi, 0);
    check("gap_busy", {31'd0, busy}, 1);
    send(24'h5A5A5A, 1'b1, "gap2");
    wait_rise(lat, 10);
    check("gap2_latency", lat, 2);
    check_bits(24'h5A5A5A, "gap2");
    wait_pulse(1'b0, 1'b0, "gap_latch");
    check("gap_no_underrun", n_underrun, ur0);

    // Underrun: frame stops without a last pixel
    fd0 = n_frame_done;
    ur0 = n_underrun;
    send(24'h0000FF, 1'b0, "ur");
    wait_rise(lat, 10);
    check("ur_latency", lat, 2);
    check_bits(24'h0000FF, "ur");
    wait_pulse(1'b1, 1'b1, "ur_pulse");
    check("ur_count", n_underrun, ur0 + 1);
    check("ur_no_frame_done", n_frame_done, fd0);

    // Offer during LATCH is held off until after frame_done
    send(24'h800001, 1'b1, "hs1");
    wait_rise(lat, 10);
    check_bits(24'h800001, "hs1");
    pix_data = 24'hFFFF00; pix_last = 1'b1; pix_valid = 1'b1;
    check("hs_ready_in_latch", {31'd0, pix_ready}, 0);
    wait_pulse(1'b0, 1'b0, "hs_latch");
    check("hs_ready_after", {31'd0, pix_ready}, 1);
    tick();
    pix_valid = 1'b0;
    wait_rise(lat, 10);
    check("hs_latency", lat, 2);
    check_bits(24'hFFFF00, "hs2");
    wait_pulse(1'b0, 1'b0, "hs2_latch");

    // Asynchronous reset mid-pixel with a pixel waiting in hold
    pix_data = 24'hFFFFFF; pix_last = 1'b0; pix_valid = 1'b1;
    tick();
    check("mr_ready_drop", {31'd0, pix_ready}, 0);
    pix_data = 24'hAAAAAA;
    tick();
    check("mr_ready_on_load", {31'd0, pix_ready}, 1);
    tick();
    pix_valid = 1'b0;
    check("mr_hold_full", {31'd0, pix_ready}, 0);
    check("mr_dout_before", {31'd0, dout}, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_dout", {31'd0, dout}, 0);
    check("mr_busy", {31'd0, busy}, 0);
    check("mr_ready", {31'd0, pix_ready}, 0);
    tick();
    tick();
    rst = 1'b0;
    #1 check("mr_ready_before_edge", {31'd0, pix_ready}, 0);
    tick();
    check("mr_ready_after", {31'd0, pix_ready}, 1);
    hi = 0;
    repeat (40) begin
      if (dout) hi++;
      tick();
    end
    check("mr_hold_discarded", hi, 0);
    check("mr_idle", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
